// File: rtl/aes_block_controller.sv
// Sequencing controller for a combinational AES-256 datapath. It holds the key and one block
// stable for a fixed settle window, then captures and round-trip checks the result.
module aes_block_controller #(
    parameter int unsigned NK            = 8,
    parameter int unsigned NB            = 4,
    parameter int unsigned NR            = 14,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key_load,
    input  logic [32*NK-1:0]  key_in,
    output logic              key_ready,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [32*NB-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [32*NB-1:0]  out_data,
    output logic              out_chk_err,
    output logic [15:0]       blk_count,
    output logic [7:0]        err_count,
    output logic [32*NB-1:0]  dp_msg,
    output logic [32*NK-1:0]  dp_key,
    input  logic [32*NB-1:0]  dp_cipher,
    input  logic [32*NB-1:0]  dp_msgout
);

    localparam int unsigned KEY_W = 32 * NK;
    localparam int unsigned BLK_W = 32 * NB;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned BLK_CNT_W = 16;
    localparam int unsigned ERR_CNT_W = 8;

    // NR only configures the external datapath; it is range-checked here with the settle window.
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 || NR < 1) begin : g_param_check
        $error("aes_block_controller: illegal SETTLE_CYCLES or NR");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        KWAIT = 2'd1,
        DWAIT = 2'd2,
        OUT   = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   key_loaded_q, key_loaded_d;
    logic [KEY_W-1:0]       key_q, key_d;
    logic [BLK_W-1:0]       msg_q, msg_d;
    logic [BLK_W-1:0]       out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_chk_err_q, out_chk_err_d;
    logic [BLK_CNT_W-1:0]   blk_count_q, blk_count_d;
    logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;
    logic                   mismatch;

    // Key load has priority over a block request arriving in the same cycle.
    assign in_ready = (state_q == IDLE) && key_loaded_q && !key_load;
    assign mismatch = (dp_msgout != msg_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            key_loaded_q  <= 1'b0;
            key_q         <= '0;
            msg_q         <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_chk_err_q <= 1'b0;
            blk_count_q   <= '0;
            err_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            key_loaded_q  <= key_loaded_d;
            key_q         <= key_d;
            msg_q         <= msg_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_chk_err_q <= out_chk_err_d;
            blk_count_q   <= blk_count_d;
            err_count_q   <= err_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        key_loaded_d  = key_loaded_q;
        key_d         = key_q;
        msg_d         = msg_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        out_chk_err_d = out_chk_err_q;
        blk_count_d   = blk_count_q;
        err_count_d   = err_count_q;

        unique case (state_q)
            IDLE: begin
                if (key_load) begin
                    key_d        = key_in;
                    key_loaded_d = 1'b0;
                    cnt_d        = CNT_W'(SETTLE_CYCLES);
                    state_d      = KWAIT;
                end else if (in_valid && in_ready) begin
                    msg_d   = in_data;
                    cnt_d   = CNT_W'(SETTLE_CYCLES);
                    state_d = DWAIT;
                end
            end
            KWAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    key_loaded_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            DWAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    out_data_d    = dp_cipher;
                    out_chk_err_d = mismatch;
                    out_valid_d   = 1'b1;
                    blk_count_d   = blk_count_q + BLK_CNT_W'(1);
                    if (mismatch && (err_count_q != {ERR_CNT_W{1'b1}})) begin
                        err_count_d = err_count_q + ERR_CNT_W'(1);
                    end
                    state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    out_valid_d   = 1'b0;
                    out_chk_err_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign key_ready   = key_loaded_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_chk_err = out_chk_err_q;
    assign blk_count   = blk_count_q;
    assign err_count   = err_count_q;
    assign dp_msg      = msg_q;
    assign dp_key      = key_q;

endmodule

// File: doc/aes_block_controller.md
Name: aes_block_controller

Overview:
- Sequencing controller for the combinational AES-256 encrypt/decrypt datapath (key expansion, encryption, round-trip decryption).
- Holds the session key and one message block stable at the datapath inputs for a fixed multicycle settle window.
- Captures the cipher result, checks that the round-trip plaintext matches the input, and returns the result over a valid/ready handshake.
- Sits between a bus-side requester and the datapath instance; keeps statistics counters.

Parameters:
- NK, 8, key length in 32-bit words
- NB, 4, block size in 32-bit words
- NR, 14, round count (passed through to the datapath; not used in logic)
- SETTLE_CYCLES, 4, multicycle settle window in clocks; legal range 1..255

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- key_load  in  1  one-cycle request to load key_in
- key_in  in  32*NK  new session key
- key_ready  out  1  key loaded and settled
- in_valid  in  1  block request valid
- in_ready  out  1  controller can accept a block
- in_data  in  32*NB  plaintext block
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  32*NB  captured cipher block
- out_chk_err  out  1  round-trip mismatch flag for out_data
- blk_count  out  16  blocks completed, wraps
- err_count  out  8  check failures, saturates at 255
- dp_msg  out  32*NB  to datapath msg input
- dp_key  out  32*NK  to datapath key input
- dp_cipher  in  32*NB  from datapath cipher output
- dp_msgout  in  32*NB  from datapath round-trip plaintext output

Behaviour:
- Reset (async, rst_n=0): state=IDLE; counter=0.
  - All of these are 0: dp_msg, dp_key, out_data, out_valid, out_chk_err, key_ready (key_loaded=0), blk_count, err_count.
  - Reset mid-operation discards any in-flight block and the key.
- States:
  - IDLE: waiting for key load or block request.
  - KWAIT: key expansion settling.
  - DWAIT: datapath settling for one block.
  - OUT: result held for the consumer.
- IDLE:
  - If key_load=1: latch key_in into dp_key, clear key_ready, load counter with SETTLE_CYCLES, go to KWAIT.
  - Otherwise, on in_valid & in_ready: latch in_data into dp_msg and msg_q, load counter with SETTLE_CYCLES, go to DWAIT.
- in_ready is combinational: (state==IDLE) & key_loaded & ~key_load. Key load therefore wins over a simultaneous in_valid; that block is not accepted in that cycle.
- KWAIT: decrement the counter each cycle. On the cycle the counter is 1: set key_loaded (key_ready=1) and go to IDLE. key_load in KWAIT, DWAIT or OUT is ignored.
- DWAIT: decrement the counter each cycle. On the cycle the counter is 1:
  - out_data <= dp_cipher;
  - out_chk_err <= (dp_msgout != msg_q);
  - out_valid <= 1;
  - blk_count += 1 (wraps at 16 bits);
  - if mismatch, err_count += 1, saturating at 255;
  - go to OUT.
- Latency: out_valid rises exactly SETTLE_CYCLES clock edges after the accepting edge. dp_msg and dp_key must not change during KWAIT, DWAIT or OUT.
- OUT:
  - out_data and out_chk_err stay stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: clear out_valid, go to IDLE. out_data keeps its value; out_chk_err is cleared.
  - in_ready is 0 throughout OUT, so the next block is accepted no earlier than the cycle after the handshake.
- Throughput: one block per SETTLE_CYCLES+2 cycles with out_ready held at 1.
- Boundaries:
  - SETTLE_CYCLES=1 gives a one-cycle DWAIT.
  - A request before the first key load is stalled (in_ready=0).
  - Reloading the key leaves the counters unchanged.

Test Plan:
- Reset then key load: key 000102…1f in datapath byte order, key_load pulse -> key_ready=0 for 4 cycles, then 1; in_ready=0 before that point.
- FIPS-197 AES-256 vector: in_data 00112233445566778899aabbccddeeff (datapath byte order), out_ready=1 -> out_valid 4 edges after accept; out_data=8ea2b7ca516745bfeafc49904b496089 (same byte order); out_chk_err=0; blk_count=1.
- Backpressure: out_ready=0 for 10 cycles -> out_valid, out_data and out_chk_err stable; in_ready=0; a second in_valid is not accepted until one cycle after the handshake.
- Check failure: bench forces dp_msgout ^= 1 during DWAIT -> out_chk_err=1 and err_count increments; 300 forced failures -> err_count=255.
- Simultaneous key_load and in_valid in IDLE -> key path taken, block not accepted; block accepted in the first IDLE cycle after KWAIT.
- Reset mid-DWAIT: rst_n low for 1 cycle -> out_valid=0, key_ready=0, counters=0; no out_valid until a new key load and request.
